// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and pipeline controller state encoding.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the operands read in IF/ID.
import cpu_types_pkg::*;

module hazard_detect (
  input  logic     dREN_ex,
  input  logic     RegWr_ex,
  input  regbits_t wsel_ex,
  input  regbits_t rs_id,
  input  regbits_t rt_id,
  input  logic     uses_rt_id,
  output logic     load_use
);

  // $0 is hardwired, so a load targeting it never creates a dependency.
  always_comb begin
    load_use = dREN_ex & RegWr_ex & (wsel_ex != '0) &
               ((wsel_ex == rs_id) | (uses_rt_id & (wsel_ex == rt_id)));
  end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencer: latch enables/flushes, data-memory wait and halt FSM,
// stall counter and memory-timeout watchdog.
//   state    | meaning
//   RUN      | normal issue
//   MEM_WAIT | EX/MEM access outstanding, pipeline frozen
//   HALTED   | halt drained, everything frozen until reset
import cpu_types_pkg::*;

module pipeline_controller #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_mem,
  input  logic             dWEN_mem,
  input  logic             halt_mem,
  input  logic             dREN_ex,
  input  logic             RegWr_ex,
  input  regbits_t         wsel_ex,
  input  regbits_t         rs_id,
  input  regbits_t         rt_id,
  input  logic             uses_rt_id,
  input  logic             branch_taken_ex,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             imemREN,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  ctrl_state_t       state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              back_stall;
  logic              load_use;

  hazard_detect u_hazard_detect (
    .dREN_ex    (dREN_ex),
    .RegWr_ex   (RegWr_ex),
    .wsel_ex    (wsel_ex),
    .rs_id      (rs_id),
    .rt_id      (rt_id),
    .uses_rt_id (uses_rt_id),
    .load_use   (load_use)
  );

  assign back_stall = (dREN_mem | dWEN_mem) & ~dhit;

  always_comb begin
    state_next  = state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    imemREN     = (state != HALTED);

    if (state != HALTED) begin
      if (back_stall) begin
        // Bubble into MEM/WB so the frozen WB instruction is not written twice.
        memwb_flush = 1'b1;
        state_next  = MEM_WAIT;
      end else if (halt_mem) begin
        memwb_en    = 1'b1;
        exmem_flush = 1'b1;
        state_next  = HALTED;
      end else begin
        state_next = RUN;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        if (branch_taken_ex) begin
          pc_en      = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          idex_flush = 1'b1;
        end else if (!ihit) begin
          ifid_flush = 1'b1;
          idex_en    = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          idex_en = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= RUN;
      halt        <= 1'b0;
      stall_cnt   <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_next;
      halt  <= (state_next == HALTED);

      if (!pc_en && (state != HALTED) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);

      if ((state == MEM_WAIT) && (state_next == MEM_WAIT)) begin
        if (wait_cnt != WAIT_LAST)
          wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      // Watchdog is observational only; sequencing keeps waiting on dhit.
      if ((state == MEM_WAIT) && (wait_cnt == WAIT_LAST) && !dhit)
        mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: directed vectors push expected
// responses; a negedge monitor pops and compares.
import cpu_types_pkg::*;

module tb_pipeline_controller;

  localparam int CNT_W    = 32;
  localparam int MAX_WAIT = 4;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
  //  ifid_flush, idex_flush, exmem_flush, memwb_flush, imemREN}
  localparam logic [9:0] C_NORM   = 10'b1_1111_0000_1;
  localparam logic [9:0] C_BACK   = 10'b0_0000_0001_1;
  localparam logic [9:0] C_HALTC  = 10'b0_0001_0010_1;
  localparam logic [9:0] C_BR     = 10'b1_0011_1100_1;
  localparam logic [9:0] C_LU     = 10'b0_0011_0100_1;
  localparam logic [9:0] C_IMISS  = 10'b0_0111_1000_1;
  localparam logic [9:0] C_HALTED = 10'b0_0000_0000_0;

  logic CLK, nRST;
  logic ihit, dhit, dREN_mem, dWEN_mem, halt_mem, dREN_ex, RegWr_ex;
  regbits_t wsel_ex, rs_id, rt_id;
  logic uses_rt_id, branch_taken_ex;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic imemREN, halt, mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct {
    logic [9:0]       ctl;
    logic             halt;
    logic             to;
    logic [CNT_W-1:0] stall;
    string            name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  pipeline_controller #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .halt_mem(halt_mem),
    .dREN_ex(dREN_ex), .RegWr_ex(RegWr_ex), .wsel_ex(wsel_ex),
    .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .branch_taken_ex(branch_taken_ex),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .imemREN(imemREN), .halt(halt), .stall_cnt(stall_cnt),
    .mem_timeout(mem_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0;
    halt_mem = 1'b0; dREN_ex = 1'b0; RegWr_ex = 1'b0; wsel_ex = '0;
    rs_id = '0; rt_id = '0; uses_rt_id = 1'b0; branch_taken_ex = 1'b0;
  endtask

  // Inputs for the cycle must already be set; this pushes what the DUT must show.
  task automatic expect_cyc(input logic [9:0] ctl, input logic h, input logic to,
                            input int stall, input string name);
    exp_t e;
    e.ctl = ctl; e.halt = h; e.to = to; e.stall = CNT_W'(stall); e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
    idle();
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [9:0] act;
      e = exp_q.pop_front();
      act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush, imemREN};
      checks++;
      if (act !== e.ctl || halt !== e.halt || mem_timeout !== e.to || stall_cnt !== e.stall) begin
        errors++;
        $display("FAIL %s: actual ctl=%b halt=%b timeout=%b stall=%0d, required ctl=%b halt=%b timeout=%b stall=%0d",
                 e.name, act, halt, mem_timeout, stall_cnt, e.ctl, e.halt, e.to, e.stall);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL time_limit: actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    idle();
    nRST = 1'b0;
    #1;
    expect_cyc(C_NORM, 0, 0, 0, "reset_initial");
    repeat (2) @(posedge CLK);
    #1; nRST = 1'b1;

    next_cyc(); expect_cyc(C_NORM, 0, 0, 0, "idle_run");
    next_cyc(); dREN_ex = 1; RegWr_ex = 1; wsel_ex = 5'd5; rs_id = 5'd5;
    expect_cyc(C_LU, 0, 0, 0, "load_use_rs");
    next_cyc(); expect_cyc(C_NORM, 0, 0, 1, "after_load_use");
    next_cyc(); dREN_ex = 1; RegWr_ex = 1; wsel_ex = 5'd0; rs_id = 5'd0;
    expect_cyc(C_NORM, 0, 0, 1, "load_to_r0_no_stall");
    next_cyc(); dREN_ex = 1; RegWr_ex = 1; wsel_ex = 5'd7; rs_id = 5'd3; rt_id = 5'd7; uses_rt_id = 1;
    expect_cyc(C_LU, 0, 0, 1, "load_use_rt");
    next_cyc(); dREN_ex = 1; RegWr_ex = 1; wsel_ex = 5'd7; rs_id = 5'd3; rt_id = 5'd7; uses_rt_id = 0;
    expect_cyc(C_NORM, 0, 0, 2, "rt_unused_no_stall");
    next_cyc(); dREN_ex = 1; RegWr_ex = 0; wsel_ex = 5'd9; rs_id = 5'd9;
    expect_cyc(C_NORM, 0, 0, 2, "no_regwr_no_stall");

    // Enter MEM_WAIT, then reset in the middle of it.
    next_cyc(); dREN_mem = 1; dhit = 0; expect_cyc(C_BACK, 0, 0, 2, "back_stall_run");
    next_cyc(); dREN_mem = 1; dhit = 0; expect_cyc(C_BACK, 0, 0, 3, "back_stall_wait");
    next_cyc(); nRST = 0; expect_cyc(C_NORM, 0, 0, 0, "reset_mid_wait");
    next_cyc(); nRST = 1; expect_cyc(C_NORM, 0, 0, 0, "run_after_reset");

    for (int i = 0; i < 3; i++) begin
      next_cyc(); dREN_mem = 1; dhit = 0; expect_cyc(C_BACK, 0, 0, i, "dmiss_3cyc");
    end
    next_cyc(); dREN_mem = 1; dhit = 1; expect_cyc(C_NORM, 0, 0, 3, "dhit_advance");
    next_cyc(); expect_cyc(C_NORM, 0, 0, 3, "run_after_wait");

    next_cyc(); dWEN_mem = 1; dhit = 0; expect_cyc(C_BACK, 0, 0, 3, "store_miss");
    next_cyc(); dWEN_mem = 1; dhit = 1; ihit = 0; expect_cyc(C_IMISS, 0, 0, 4, "dhit_with_imiss");
    next_cyc(); expect_cyc(C_NORM, 0, 0, 5, "run_after_imiss");

    next_cyc(); branch_taken_ex = 1; ihit = 0; dREN_ex = 1; RegWr_ex = 1; wsel_ex = 5'd4; rs_id = 5'd4;
    expect_cyc(C_BR, 0, 0, 5, "branch_beats_lu_imiss");
    next_cyc(); ihit = 0; dREN_ex = 1; RegWr_ex = 1; wsel_ex = 5'd4; rs_id = 5'd4;
    expect_cyc(C_LU, 0, 0, 5, "lu_beats_imiss");

    // Watchdog: six cycles of dhit low.
    for (int i = 0; i < 6; i++) begin
      next_cyc(); dREN_mem = 1; dhit = 0;
      expect_cyc(C_BACK, 0, (i == 5), 6 + i, "timeout_wait");
    end
    next_cyc(); dREN_mem = 1; dhit = 1; expect_cyc(C_NORM, 0, 1, 12, "timeout_sticky_hit");
    next_cyc(); expect_cyc(C_NORM, 0, 1, 12, "timeout_sticky_run");

    next_cyc(); halt_mem = 1; branch_taken_ex = 1;
    expect_cyc(C_HALTC, 0, 1, 12, "halt_drain");
    for (int i = 0; i < 10; i++) begin
      next_cyc();
      branch_taken_ex = i[0];
      dREN_mem = i[1];
      ihit = ~i[2];
      expect_cyc(C_HALTED, 1, 1, 13, "halted_hold");
    end

    next_cyc(); nRST = 0; expect_cyc(C_NORM, 0, 0, 0, "reset_from_halt");
    next_cyc(); nRST = 1; expect_cyc(C_NORM, 0, 0, 0, "run_after_halt_reset");

    @(posedge CLK);
    repeat (3) begin
      if (exp_q.size() == 0) break;
      @(negedge CLK);
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual pending=%0d required=0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
